// File: rtl/nes_pad_reader_if.sv
// nes_pad_reader_if
// Bundles the signals that pass between the NES pad reader and the rest of the
// system: the 3-wire controller link (pad_latch, pad_pulse, pad_data), the
// immediate-poll request, and the decoded button report.
//   master : the side that drives pad_data/poll_req and consumes the report
//            (controller + host logic, or a testbench)
//   slave  : the pad reader itself
//   pad_data        controller serial data, active-low, asynchronous
//   poll_req        one-cycle request for an immediate poll
//   pad_latch       latch strobe to the controller
//   pad_pulse       shift clock to the controller
//   buttons         {A,B,SEL,START,UP,DN,L,R}, 1 = pressed
//   buttons_valid   one-cycle strobe when buttons updates
//   buttons_changed set with buttons_valid when the new value differs
interface nes_pad_reader_if;
    logic       pad_data;
    logic       poll_req;
    logic       pad_latch;
    logic       pad_pulse;
    logic [7:0] buttons;
    logic       buttons_valid;
    logic       buttons_changed;

    modport master (
        output pad_data,
        output poll_req,
        input  pad_latch,
        input  pad_pulse,
        input  buttons,
        input  buttons_valid,
        input  buttons_changed
    );

    modport slave (
        input  pad_data,
        input  poll_req,
        output pad_latch,
        output pad_pulse,
        output buttons,
        output buttons_valid,
        output buttons_changed
    );
endinterface

// File: rtl/nes_pad_reader.sv
// nes_pad_reader
// Polls a physical NES controller over its latch/pulse/data serial link at a
// fixed rate (or on request) and reports the 8 buttons as an active-high vector
// with a one-cycle valid strobe plus a "changed since last report" flag.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   pad  nes_pad_reader_if.slave: pad_data/poll_req in, pad_latch/pad_pulse,
//        buttons, buttons_valid, buttons_changed out (all outputs registered)
// Parameters:
//   POLL_CYCLES   clk cycles between automatic poll starts
//   LATCH_CYCLES  latch high time
//   HALF_CYCLES   half-period of pulse, also the gap after the latch
module nes_pad_reader #(
    parameter int POLL_CYCLES  = 1666667,
    parameter int LATCH_CYCLES = 1200,
    parameter int HALF_CYCLES  = 600
) (
    input logic             clk,
    input logic             rst,
    nes_pad_reader_if.slave pad
);

    localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int TIMER_W   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        GAP,
        PHI,
        PLO,
        DONE
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] poll_timer;
    logic [PHASE_W-1:0] phase;
    logic [2:0]         bit_idx;
    logic               idx_done;
    logic [7:0]         shift_reg;
    logic               sync1;
    logic               sync2;
    logic               tick;
    logic               sample_bit;
    logic               latch_last;
    logic               half_last;

    assign tick       = (poll_timer == TIMER_W'(POLL_CYCLES - 1));
    assign sample_bit = ~sync2;
    assign latch_last = (phase == PHASE_W'(LATCH_CYCLES - 1));
    assign half_last  = (phase == PHASE_W'(HALF_CYCLES - 1));

    // Two-flop synchronizer for the asynchronous pad data line. Resets to 1,
    // which is the idle (nothing pressed) level of the active-low line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pad.pad_data;
            sync2 <= sync1;
        end
    end

    // Free-running poll timer; tick marks its last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            poll_timer <= '0;
        end else if (tick) begin
            poll_timer <= '0;
        end else begin
            poll_timer <= poll_timer + TIMER_W'(1);
        end
    end

    // Frame sequencer. Outputs are set on the edge that enters each state so
    // pad_latch is high exactly while in LATCH and pad_pulse exactly while in
    // PHI. The report is published on the edge that enters DONE, so
    // buttons_valid is high during the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            phase               <= '0;
            bit_idx             <= 3'd0;
            idx_done            <= 1'b0;
            shift_reg           <= 8'h00;
            pad.pad_latch       <= 1'b0;
            pad.pad_pulse       <= 1'b0;
            pad.buttons         <= 8'h00;
            pad.buttons_valid   <= 1'b0;
            pad.buttons_changed <= 1'b0;
        end else begin
            pad.buttons_valid   <= 1'b0;
            pad.buttons_changed <= 1'b0;
            case (state)
                IDLE: begin
                    // Requests arriving in any other state are simply ignored.
                    if (tick || pad.poll_req) begin
                        state         <= LATCH;
                        phase         <= '0;
                        pad.pad_latch <= 1'b1;
                    end
                end
                LATCH: begin
                    if (latch_last) begin
                        state         <= GAP;
                        phase         <= '0;
                        pad.pad_latch <= 1'b0;
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                GAP: begin
                    // The controller presents A as soon as it is latched.
                    if (half_last) begin
                        shift_reg[7]  <= sample_bit;
                        bit_idx       <= 3'd6;
                        idx_done      <= 1'b0;
                        state         <= PHI;
                        phase         <= '0;
                        pad.pad_pulse <= 1'b1;
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                PHI: begin
                    if (half_last) begin
                        state         <= PLO;
                        phase         <= '0;
                        pad.pad_pulse <= 1'b0;
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                PLO: begin
                    // idx_done means bit 0 was taken on the previous low phase,
                    // so this is the end of the 8th pulse and no sample remains.
                    if (half_last) begin
                        phase <= '0;
                        if (idx_done) begin
                            state               <= DONE;
                            pad.buttons         <= shift_reg;
                            pad.buttons_valid   <= 1'b1;
                            pad.buttons_changed <= (shift_reg != pad.buttons);
                        end else begin
                            shift_reg[bit_idx] <= sample_bit;
                            if (bit_idx == 3'd0) begin
                                idx_done <= 1'b1;
                            end else begin
                                bit_idx <= bit_idx - 3'd1;
                            end
                            state         <= PHI;
                            pad.pad_pulse <= 1'b1;
                        end
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader
// Self-checking bench for nes_pad_reader with short timing parameters
// (POLL=100, LATCH=4, HALF=2). A behavioural NES pad drives pad_data; expected
// reports are queued as frames are set up and compared whenever buttons_valid
// fires.
module tb_nes_pad_reader;

    localparam int POLL  = 100;
    localparam int LATCH = 4;
    localparam int HALF  = 2;

    typedef struct packed {
        logic [7:0] buttons;
        logic       changed;
    } report_t;

    logic clk;
    logic rst;

    nes_pad_reader_if pif ();

    nes_pad_reader #(
        .POLL_CYCLES (POLL),
        .LATCH_CYCLES(LATCH),
        .HALF_CYCLES (HALF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pad(pif)
    );

    int         checks = 0;
    int         errors = 0;
    int         valid_count = 0;
    report_t    sb_q[$];
    logic [7:0] sb_last = 8'h00;

    // Pad model state: pattern is the active-low frame the pad will send.
    logic [7:0] pad_pattern = 8'hFF;
    logic [7:0] pad_sr      = 8'hFF;
    logic       prev_pulse  = 1'b0;
    logic       glitch      = 1'b0;
    logic       stuck_en    = 1'b0;
    logic       stuck_val   = 1'b1;

    assign pif.pad_data = stuck_en ? stuck_val : (pad_sr[7] ^ glitch);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural controller: reloads while latched, shifts on pulse rise,
    // filling with 1s (released) like a real pad.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pif.pad_latch === 1'b1) begin
                pad_sr = pad_pattern;
            end else if (pif.pad_pulse === 1'b1 && prev_pulse == 1'b0) begin
                pad_sr = {pad_sr[6:0], 1'b1};
            end
            prev_pulse = (pif.pad_pulse === 1'b1);
        end
    end

    // Scoreboard consumer: every strobe must match the oldest queued report.
    initial begin
        report_t exp_r;
        forever begin
            @(negedge clk);
            if (pif.buttons_valid === 1'b1) begin
                valid_count++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_strobe: got buttons=%h changed=%b, required no strobe",
                             pif.buttons, pif.buttons_changed);
                end else begin
                    exp_r = sb_q.pop_front();
                    if (pif.buttons !== exp_r.buttons || pif.buttons_changed !== exp_r.changed) begin
                        errors++;
                        $display("[TB] FAIL report: got buttons=%h changed=%b, required buttons=%h changed=%b",
                                 pif.buttons, pif.buttons_changed, exp_r.buttons, exp_r.changed);
                    end
                end
            end
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got no finish, required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic push_expect(input logic [7:0] exp_buttons);
        report_t r;
        r.buttons = exp_buttons;
        r.changed = (exp_buttons != sb_last);
        sb_last   = exp_buttons;
        sb_q.push_back(r);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        pif.poll_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        sb_last = 8'h00;
    endtask

    task automatic wait_drain(input int limit, input string name);
        for (int i = 0; i < limit && sb_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d reports pending, required 0", name, sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        pif.poll_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (pif.pad_latch !== 1'b0) begin errors++; $display("[TB] FAIL reset_latch: got %b, required 0", pif.pad_latch); end
        if (pif.pad_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulse: got %b, required 0", pif.pad_pulse); end
        if (pif.buttons !== 8'h00) begin errors++; $display("[TB] FAIL reset_buttons: got %h, required 00", pif.buttons); end
        if (pif.buttons_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, required 0", pif.buttons_valid); end
        if (pif.buttons_changed !== 1'b0) begin errors++; $display("[TB] FAIL reset_changed: got %b, required 0", pif.buttons_changed); end
    endtask

    task automatic test_frame_timing();
        int   latch_rise[$];
        int   valid_at[$];
        int   latch_high = 0;
        int   pulse_high = 0;
        int   pulse_rises = 0;
        int   first_l, second_l, first_v, second_v;
        logic prev_l = 1'b0;
        logic prev_p = 1'b0;
        pad_pattern = 8'hFF;
        do_reset();
        push_expect(8'h00);
        push_expect(8'h00);
        for (int n = 1; n <= 250; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (pif.pad_latch === 1'b1 && !prev_l) latch_rise.push_back(n);
            if (pif.buttons_valid === 1'b1) valid_at.push_back(n);
            if (n < 200) begin
                if (pif.pad_latch === 1'b1) latch_high++;
                if (pif.pad_pulse === 1'b1) pulse_high++;
                if (pif.pad_pulse === 1'b1 && !prev_p) pulse_rises++;
            end
            prev_l = (pif.pad_latch === 1'b1);
            prev_p = (pif.pad_pulse === 1'b1);
        end
        first_l  = (latch_rise.size() > 0) ? latch_rise[0] : -1;
        second_l = (latch_rise.size() > 1) ? latch_rise[1] : -1;
        first_v  = (valid_at.size() > 0) ? valid_at[0] : -1;
        second_v = (valid_at.size() > 1) ? valid_at[1] : -1;
        checks += 8;
        if (first_l != POLL) begin errors++; $display("[TB] FAIL first_latch_cycle: got %0d, required %0d", first_l, POLL); end
        if (second_l != 2 * POLL) begin errors++; $display("[TB] FAIL second_latch_cycle: got %0d, required %0d", second_l, 2 * POLL); end
        if (latch_high != LATCH) begin errors++; $display("[TB] FAIL latch_width: got %0d, required %0d", latch_high, LATCH); end
        if (pulse_rises != 8) begin errors++; $display("[TB] FAIL pulse_count: got %0d, required 8", pulse_rises); end
        if (pulse_high != 8 * HALF) begin errors++; $display("[TB] FAIL pulse_high_cycles: got %0d, required %0d", pulse_high, 8 * HALF); end
        if (first_v != POLL + LATCH + 17 * HALF) begin errors++; $display("[TB] FAIL first_valid_cycle: got %0d, required %0d", first_v, POLL + LATCH + 17 * HALF); end
        if (second_v != 2 * POLL + LATCH + 17 * HALF) begin errors++; $display("[TB] FAIL second_valid_cycle: got %0d, required %0d", second_v, 2 * POLL + LATCH + 17 * HALF); end
        if (sb_q.size() != 0) begin errors++; $display("[TB] FAIL timing_reports: got %0d pending, required 0", sb_q.size()); sb_q.delete(); end
    endtask

    task automatic test_pattern();
        pad_pattern = 8'b0111_1110;
        push_expect(8'h81);
        push_expect(8'h81);
        wait_drain(300, "pattern");
    endtask

    task automatic test_poll_req();
        int vc_before;
        pad_pattern = 8'h5A;
        do_reset();
        vc_before = valid_count;
        push_expect(8'hA5);
        repeat (19) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pif.pad_latch !== 1'b0) begin errors++; $display("[TB] FAIL poll_pre_latch: got %b, required 0", pif.pad_latch); end
        pif.poll_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pif.poll_req = 1'b0;
        checks++;
        if (pif.pad_latch !== 1'b1) begin errors++; $display("[TB] FAIL poll_latch_start: got %b, required 1", pif.pad_latch); end
        repeat (5) @(negedge clk);
        pif.poll_req = 1'b1;
        repeat (25) @(negedge clk);
        pif.poll_req = 1'b0;
        wait_drain(100, "poll");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (pif.pad_latch !== 1'b0) begin errors++; $display("[TB] FAIL poll_no_refire: got latch=%b, required 0", pif.pad_latch); end
        end
        checks++;
        if (valid_count - vc_before != 1) begin
            errors++;
            $display("[TB] FAIL poll_strobe_count: got %0d, required 1", valid_count - vc_before);
        end
    endtask

    task automatic test_stuck();
        stuck_en  = 1'b1;
        stuck_val = 1'b1;
        push_expect(8'h00);
        wait_drain(250, "stuck_high");
        stuck_val = 1'b0;
        push_expect(8'hFF);
        wait_drain(250, "stuck_low");
        stuck_en  = 1'b0;
        stuck_val = 1'b1;
    endtask

    task automatic test_glitch();
        int seen = 0;
        pad_pattern = 8'hA5;
        push_expect(8'h5A);
        @(posedge clk); #2 glitch = 1'b1;
        @(posedge clk); #2 glitch = 1'b0;
        for (int i = 0; i < 150 && seen == 0; i++) begin
            @(negedge clk);
            if (pif.pad_latch === 1'b1) seen = 1;
        end
        checks++;
        if (seen == 0) begin errors++; $display("[TB] FAIL glitch_latch_timeout: got no latch, required latch"); end
        @(posedge clk); #2 glitch = 1'b1;
        @(posedge clk); #2 glitch = 1'b0;
        wait_drain(100, "glitch");
    endtask

    task automatic test_reset_midframe();
        int   seen = 0;
        int   rises = 0;
        logic prev_p = 1'b0;
        pad_pattern = 8'h3C;
        for (int i = 0; i < 150 && seen == 0; i++) begin
            @(negedge clk);
            if (pif.pad_latch === 1'b1) seen = 1;
        end
        for (int i = 0; i < 60 && rises < 4; i++) begin
            @(negedge clk);
            if (pif.pad_pulse === 1'b1 && !prev_p) rises++;
            prev_p = (pif.pad_pulse === 1'b1);
        end
        checks++;
        if (rises != 4) begin errors++; $display("[TB] FAIL midreset_pulse_timeout: got %0d rises, required 4", rises); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (pif.pad_latch !== 1'b0) begin errors++; $display("[TB] FAIL midreset_latch: got %b, required 0", pif.pad_latch); end
        if (pif.pad_pulse !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pulse: got %b, required 0", pif.pad_pulse); end
        if (pif.buttons !== 8'h00) begin errors++; $display("[TB] FAIL midreset_buttons: got %h, required 00", pif.buttons); end
        if (pif.buttons_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b, required 0", pif.buttons_valid); end
        if (pif.buttons_changed !== 1'b0) begin errors++; $display("[TB] FAIL midreset_changed: got %b, required 0", pif.buttons_changed); end
        rst     = 1'b0;
        sb_last = 8'h00;
        repeat (50) @(negedge clk);
        checks++;
        if (pif.buttons !== 8'h00) begin errors++; $display("[TB] FAIL midreset_hold: got %h, required 00", pif.buttons); end
        push_expect(8'hC3);
        wait_drain(200, "after_reset");
    endtask

    initial begin
        rst          = 1'b1;
        pif.poll_req = 1'b0;
        test_reset();
        test_frame_timing();
        test_pattern();
        test_poll_req();
        test_stuck();
        test_glitch();
        test_reset_midframe();
        repeat (5) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL final_pending: got %0d, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
